mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Memory-access stage directly downstream of the effective-address block.
- Selects the MAR source: the effective-address sum, or the zero-extended trap vector.
- Holds MAR and MDR, and runs the req/ready handshake to the unified memory for the read and write phases of LD/ST/LDI/STI/LDR/STR/TRAP.
- Returns a one-cycle R (ready) pulse to the control FSM when an access completes.

Parameters:
- ADDR_W, 16, address and MAR width.
- DATA_W, 16, data and MDR width.
- TIMEOUT, 15, max cycles in REQ without mem_ready before an abort (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- eab_out  in  16  effective address from the EAB adder.
- ir_trapvect8  in  8  IR[7:0].
- sel_marmux  in  1  1: eab_out, 0: ZEXT(ir_trapvect8).
- marmux_out  out  16  combinational MARMUX result, for gateMARMUX onto the bus.
- bus_in  in  16  system bus.
- ld_mar  in  1  load MAR from bus_in.
- ld_mdr  in  1  load MDR from bus_in (CPU-side load).
- mem_en  in  1  start-access pulse.
- mem_rw  in  1  1: write, 0: read; sampled with mem_en.
- mar  out  16  MAR register.
- mdr  out  16  MDR register, for gateMDR.
- r  out  1  access-complete pulse.
- busy  out  1  access in flight.
- mem_err  out  1  sticky timeout flag.
- mem_req  out  1  request to memory.
- mem_we  out  1  write strobe to memory.
- mem_addr  out  16  equals mar.
- mem_wdata  out  16  equals mdr.
- mem_rdata  in  16  read data from memory.
- mem_ready  in  1  memory handshake acknowledge.

Behaviour:
- Reset (async, reset_n=0), all registered outputs cleared:
  - mar=0, mdr=0, r=0, busy=0, mem_err=0, mem_req=0, mem_we=0.
  - FSM=IDLE, counter=0.
- Reset mid-access aborts immediately; no r pulse follows.
- MARMUX is combinational: marmux_out = sel_marmux ? eab_out : {8'h00, ir_trapvect8}.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - ld_mar: mar<=bus_in.
  - ld_mdr: mdr<=bus_in.
  - mem_en=1: latch mem_rw into a write flag, clear mem_err and the counter, go to REQ.
  - ld_mar and mem_en in the same cycle: the access uses the newly loaded MAR, because REQ drives the registered mar.
- REQ:
  - Drives mem_req=1 and mem_we=write flag; busy=1.
  - mem_addr and mem_wdata are stable for the whole state.
  - mem_ready=1: on a read, mdr<=mem_rdata; go to DONE.
  - No ready: counter increments.
  - Counter reaches TIMEOUT-1 with no ready: go to DONE with mem_err<=1; mdr is unchanged.
  - Zero-wait memory (ready in the first REQ cycle) is legal.
- DONE: r=1 for exactly one cycle, mem_req=0, busy=1, then return to IDLE.
- Completion latency: r is asserted 2 cycles after the mem_en edge for zero-wait memory, and N+2 cycles for N wait cycles.
- Back-to-back: mem_en in the cycle after DONE starts a new access. The minimum access period is 3 cycles.
- While busy, ld_mar, ld_mdr and mem_en are ignored. The control FSM guarantees they are not asserted; the block must not corrupt mar or mdr if they are.
- mem_ready outside REQ is ignored.
- mem_err holds until the next mem_en is accepted.
- Widths are fixed to 16; no arithmetic beyond the counter. The counter is 8-bit, saturating.

Decomposition:
- Shared package lc3_pkg: FSM state enum (IDLE/REQ/DONE), MARMUX select constants, and the TRAP vector zero-extend width constant.
- One natural sub-module, marmux: the combinational 2:1 select plus zero-extend. Everything else lives in mem_access_ctrl.

Test Plan:
- Reset state: hold reset_n=0 mid-REQ -> all outputs 0, FSM IDLE; release, no r pulse.
- Zero-wait read: bus_in=16'h3000, ld_mar; mem_en, mem_rw=0; mem_ready=1 in the first REQ cycle with mem_rdata=16'hBEEF -> mem_addr=16'h3000, mdr=16'hBEEF, r high exactly one cycle, 2 cycles after mem_en.
- Wait-state write: mdr=16'h1234 via ld_mdr, mar=16'hFE02; mem_en, mem_rw=1; ready after 3 cycles -> mem_we=1 and mem_wdata=16'h1234 held for all 4 REQ cycles; r at cycle 5.
- MARMUX select: sel_marmux=0, ir_trapvect8=8'h25 -> marmux_out=16'h0025. sel_marmux=1, eab_out=16'h4011 -> 16'h4011.
- Timeout: TIMEOUT=15, mem_ready never asserted -> r after 16 cycles, mem_err=1, mdr unchanged; the next mem_en clears mem_err.
- Simultaneous ld_mar+mem_en: bus_in=16'h0500 -> mem_addr=16'h0500 in the first REQ cycle. ld_mar with bus_in=16'hFFFF while busy -> mar stays 16'h0500.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 memory-access stage:
// FSM state encoding, MARMUX select values and trap-vector width.
package lc3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  localparam logic MARMUX_SEL_TRAP = 1'b0;
  localparam logic MARMUX_SEL_EAB  = 1'b1;

  localparam int TRAPVECT_W = 8;
  localparam int CNT_W      = 8;

endpackage

// File: rtl/marmux.sv
// MARMUX: picks the EAB sum or the zero-extended 8-bit trap vector
// as the address presented to the bus.
module marmux
  import lc3_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0]     eab_out,
  input  logic [TRAPVECT_W-1:0] ir_trapvect8,
  input  logic                  sel_marmux,
  output logic [ADDR_W-1:0]     marmux_out
);

  assign marmux_out = (sel_marmux == MARMUX_SEL_EAB)
                    ? eab_out
                    : {{(ADDR_W-TRAPVECT_W){1'b0}}, ir_trapvect8};

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-access stage: holds MAR/MDR and runs the req/ready handshake with
// the unified memory, returning a one-cycle R pulse when an access completes.
module mem_access_ctrl
  import lc3_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     eab_out,
  input  logic [TRAPVECT_W-1:0] ir_trapvect8,
  input  logic                  sel_marmux,
  output logic [ADDR_W-1:0]     marmux_out,
  input  logic [DATA_W-1:0]     bus_in,
  input  logic                  ld_mar,
  input  logic                  ld_mdr,
  input  logic                  mem_en,
  input  logic                  mem_rw,
  output logic [ADDR_W-1:0]     mar,
  output logic [DATA_W-1:0]     mdr,
  output logic                  r,
  output logic                  busy,
  output logic                  mem_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ready
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_e        state_q;
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] mdr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, r_q, busy_q, mem_err_q, mem_req_q, mem_we_q;

  marmux #(.ADDR_W(ADDR_W)) u_marmux (
    .eab_out      (eab_out),
    .ir_trapvect8 (ir_trapvect8),
    .sel_marmux   (sel_marmux),
    .marmux_out   (marmux_out)
  );

  // Saturating wait-cycle counter.
  assign cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      mar_q     <= '0;
      mdr_q     <= '0;
      cnt_q     <= '0;
      write_q   <= 1'b0;
      r_q       <= 1'b0;
      busy_q    <= 1'b0;
      mem_err_q <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking default; a later assignment in this block wins,
      // so r_q is high only in the cycle the REQ branch sets it.
      r_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ld_mar) mar_q <= bus_in;
          if (ld_mdr) mdr_q <= bus_in;
          if (mem_en) begin
            write_q   <= mem_rw;
            mem_err_q <= 1'b0;
            cnt_q     <= '0;
            mem_req_q <= 1'b1;
            mem_we_q  <= mem_rw;
            busy_q    <= 1'b1;
            state_q   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_ready || cnt_q == CNT_LAST) begin
            if (mem_ready && !write_q) mdr_q <= mem_rdata;
            if (!mem_ready) mem_err_q <= 1'b1;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            r_q       <= 1'b1;
            state_q   <= ST_DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mar       = mar_q;
  assign mdr       = mdr_q;
  assign r         = r_q;
  assign busy      = busy_q;
  assign mem_err   = mem_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl: reads, wait-state writes,
// timeout, MARMUX, busy-protection and asynchronous reset.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] eab_out, bus_in, mem_rdata;
  logic [7:0]  ir_trapvect8;
  logic        sel_marmux, ld_mar, ld_mdr, mem_en, mem_rw, mem_ready;
  logic [15:0] marmux_out, mar, mdr, mem_addr, mem_wdata;
  logic        r, busy, mem_err, mem_req, mem_we;

  int errors = 0;
  int checks = 0;

  mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(15)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .eab_out      (eab_out),
    .ir_trapvect8 (ir_trapvect8),
    .sel_marmux   (sel_marmux),
    .marmux_out   (marmux_out),
    .bus_in       (bus_in),
    .ld_mar       (ld_mar),
    .ld_mdr       (ld_mdr),
    .mem_en       (mem_en),
    .mem_rw       (mem_rw),
    .mar          (mar),
    .mdr          (mdr),
    .r            (r),
    .busy         (busy),
    .mem_err      (mem_err),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, ".mar"},     32'(mar),     32'h0);
    check({tag, ".mdr"},     32'(mdr),     32'h0);
    check({tag, ".r"},       32'(r),       32'h0);
    check({tag, ".busy"},    32'(busy),    32'h0);
    check({tag, ".mem_err"}, 32'(mem_err), 32'h0);
    check({tag, ".mem_req"}, 32'(mem_req), 32'h0);
    check({tag, ".mem_we"},  32'(mem_we),  32'h0);
  endtask

  initial begin
    reset_n = 1'b0; eab_out = '0; bus_in = '0; mem_rdata = '0; ir_trapvect8 = '0;
    sel_marmux = 1'b0; ld_mar = 1'b0; ld_mdr = 1'b0; mem_en = 1'b0; mem_rw = 1'b0;
    mem_ready = 1'b0;
    tick(); tick();
    check_idle_zero("reset");
    reset_n = 1'b1;
    tick();

    // MARMUX
    sel_marmux = 1'b0; ir_trapvect8 = 8'h25; eab_out = 16'h4011; #1;
    check("marmux_trap", 32'(marmux_out), 32'h0025);
    sel_marmux = 1'b1; #1;
    check("marmux_eab", 32'(marmux_out), 32'h4011);

    // Zero-wait read
    bus_in = 16'h3000; ld_mar = 1'b1; tick(); ld_mar = 1'b0;
    check("rd0.mar", 32'(mar), 32'h3000);
    mem_en = 1'b1; mem_rw = 1'b0; tick(); mem_en = 1'b0;
    check("rd0.req",  32'(mem_req),  32'h1);
    check("rd0.we",   32'(mem_we),   32'h0);
    check("rd0.busy", 32'(busy),     32'h1);
    check("rd0.addr", 32'(mem_addr), 32'h3000);
    check("rd0.r_early", 32'(r), 32'h0);
    mem_ready = 1'b1; mem_rdata = 16'hBEEF; tick(); mem_ready = 1'b0;
    check("rd0.r",        32'(r),       32'h1);
    check("rd0.mdr",      32'(mdr),     32'hBEEF);
    check("rd0.req_done", 32'(mem_req), 32'h0);
    check("rd0.busy_done", 32'(busy),   32'h1);
    tick();
    check("rd0.r_once", 32'(r),    32'h0);
    check("rd0.idle",   32'(busy), 32'h0);

    // Wait-state write: ready in the 4th REQ cycle, r at cycle 5
    bus_in = 16'h1234; ld_mdr = 1'b1; tick(); ld_mdr = 1'b0;
    bus_in = 16'hFE02; ld_mar = 1'b1; tick(); ld_mar = 1'b0;
    mem_en = 1'b1; mem_rw = 1'b1; mem_rdata = 16'hDEAD; tick(); mem_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wr.req%0d", i),   32'(mem_req),   32'h1);
      check($sformatf("wr.we%0d", i),    32'(mem_we),    32'h1);
      check($sformatf("wr.wdata%0d", i), 32'(mem_wdata), 32'h1234);
      check($sformatf("wr.addr%0d", i),  32'(mem_addr),  32'hFE02);
      check($sformatf("wr.r%0d", i),     32'(r),         32'h0);
      if (i == 3) mem_ready = 1'b1;
      tick();
    end
    mem_ready = 1'b0;
    check("wr.r",   32'(r),      32'h1);
    check("wr.mdr", 32'(mdr),    32'h1234);
    check("wr.we_done", 32'(mem_we), 32'h0);
    tick();
    check("wr.r_once", 32'(r), 32'h0);

    // mem_ready outside REQ ignored
    mem_ready = 1'b1; mem_rdata = 16'h5555; tick(); mem_ready = 1'b0;
    check("stray_ready.mdr", 32'(mdr), 32'h1234);
    check("stray_ready.r",   32'(r),   32'h0);

    // Timeout: 15 REQ cycles, r in cycle 16
    mem_en = 1'b1; mem_rw = 1'b0; mem_rdata = 16'hAAAA; tick(); mem_en = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      check($sformatf("to.req%0d", i), 32'(mem_req), 32'h1);
      check($sformatf("to.r%0d", i),   32'(r),       32'h0);
      tick();
    end
    check("to.r",       32'(r),       32'h1);
    check("to.mem_err", 32'(mem_err), 32'h1);
    check("to.mdr",     32'(mdr),     32'h1234);
    tick();
    check("to.err_hold", 32'(mem_err), 32'h1);
    check("to.idle",     32'(busy),    32'h0);

    // ld_mar + mem_en together; mem_err cleared by the new access
    bus_in = 16'h0500; ld_mar = 1'b1; mem_en = 1'b1; mem_rw = 1'b0; tick();
    check("sim.addr",    32'(mem_addr), 32'h0500);
    check("sim.err_clr", 32'(mem_err),  32'h0);
    check("sim.busy",    32'(busy),     32'h1);

    // Loads and mem_en while busy must not disturb MAR/MDR
    bus_in = 16'hFFFF; ld_mar = 1'b1; ld_mdr = 1'b1; mem_en = 1'b1; tick();
    check("busy.mar", 32'(mar), 32'h0500);
    check("busy.mdr", 32'(mdr), 32'h1234);
    mem_ready = 1'b1; mem_rdata = 16'h7777; tick(); mem_ready = 1'b0;
    check("busy.r",       32'(r),   32'h1);
    check("busy.mdr_rd",  32'(mdr), 32'h7777);
    check("busy.mar_rd",  32'(mar), 32'h0500);
    tick();
    check("done.mar",  32'(mar),  32'h0500);
    check("done.mdr",  32'(mdr),  32'h7777);
    check("done.busy", 32'(busy), 32'h0);
    ld_mar = 1'b0; ld_mdr = 1'b0; mem_en = 1'b0; tick();
    check("done.no_req", 32'(mem_req), 32'h0);

    // Asynchronous reset in the middle of REQ
    mem_en = 1'b1; tick(); mem_en = 1'b0;
    check("rst.in_req", 32'(mem_req), 32'h1);
    #2 reset_n = 1'b0; #1;
    check_idle_zero("rst_async");
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rst.no_r%0d", i),  32'(r),    32'h0);
      check($sformatf("rst.idle%0d", i),  32'(busy), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
